// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad front end: walks the row drive, synchronizes and debounces
// the active-low columns, and decodes a held key into a code plus press strobe.
module keypad_scan_debounce #(
    parameter int unsigned SCAN_DIV        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] matricial_col,
    output logic [3:0] matricial_lin,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_pulse
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DEB_FULL  = CW'(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [3:0]    IDLE      = 4'b1111;

    typedef enum logic [2:0] {
        SCAN,
        SETTLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    col_m;
    logic [3:0]    col_s;
    logic [1:0]    row_d1;
    logic [1:0]    row_d2;
    logic [1:0]    row_idx;
    logic [1:0]    row_nxt;
    logic [SW-1:0] scan_cnt;
    logic [SW-1:0] scan_cnt_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [3:0]    pat;
    logic [3:0]    pat_nxt;
    logic          valid_nxt;
    logic [3:0]    code_nxt;
    logic          pulse_nxt;

    // Exactly one column low: the only pattern that can start a press.
    function automatic logic is_single(input logic [3:0] c);
        return (c == 4'b1110) || (c == 4'b1101) || (c == 4'b1011) || (c == 4'b0111);
    endfunction

    function automatic logic [3:0] decode(input logic [1:0] r, input logic [3:0] p);
        logic [1:0] c;
        logic [3:0] code;
        case (p)
            4'b1101: c = 2'd1;
            4'b1011: c = 2'd2;
            4'b0111: c = 2'd3;
            default: c = 2'd0;
        endcase
        case ({r, c})
            4'h0:    code = 4'd1;
            4'h1:    code = 4'd2;
            4'h2:    code = 4'd3;
            4'h3:    code = 4'd10;
            4'h4:    code = 4'd4;
            4'h5:    code = 4'd5;
            4'h6:    code = 4'd6;
            4'h7:    code = 4'd11;
            4'h8:    code = 4'd7;
            4'h9:    code = 4'd8;
            4'hA:    code = 4'd9;
            4'hB:    code = 4'd12;
            4'hC:    code = 4'd15;
            4'hD:    code = 4'd0;
            4'hE:    code = 4'd13;
            default: code = 4'd14;
        endcase
        return code;
    endfunction

    // Column synchronizer, with the driven row tracked alongside each sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_m  <= IDLE;
            col_s  <= IDLE;
            row_d1 <= 2'd0;
            row_d2 <= 2'd0;
        end else begin
            col_m  <= matricial_col;
            col_s  <= col_m;
            row_d1 <= row_idx;
            row_d2 <= row_d1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SCAN;
            row_idx       <= 2'd0;
            scan_cnt      <= '0;
            cnt           <= '0;
            pat           <= IDLE;
            matricial_lin <= 4'b1110;
            key_valid     <= 1'b0;
            key_code      <= 4'd0;
            key_pulse     <= 1'b0;
        end else begin
            state         <= state_nxt;
            row_idx       <= row_nxt;
            scan_cnt      <= scan_cnt_nxt;
            cnt           <= cnt_nxt;
            pat           <= pat_nxt;
            matricial_lin <= ~(4'b0001 << row_nxt);
            key_valid     <= valid_nxt;
            key_code      <= code_nxt;
            key_pulse     <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        row_nxt      = row_idx;
        scan_cnt_nxt = scan_cnt;
        cnt_nxt      = cnt;
        pat_nxt      = pat;
        valid_nxt    = key_valid;
        code_nxt     = key_code;
        pulse_nxt    = 1'b0;
        case (state)
            SCAN: begin
                // row_d2 names the row that produced col_s, so the row may jump back.
                if (is_single(col_s)) begin
                    pat_nxt      = col_s;
                    row_nxt      = row_d2;
                    scan_cnt_nxt = '0;
                    cnt_nxt      = '0;
                    state_nxt    = SETTLE;
                end else if (scan_cnt == SCAN_LAST) begin
                    scan_cnt_nxt = '0;
                    row_nxt      = row_idx + 2'd1;
                end else begin
                    scan_cnt_nxt = scan_cnt + SW'(1);
                end
            end
            SETTLE: begin
                // Flush samples launched before the row was frozen.
                if (cnt == CW'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = DEBOUNCE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DEBOUNCE: begin
                if (col_s != pat) begin
                    cnt_nxt      = '0;
                    row_nxt      = row_idx + 2'd1;
                    scan_cnt_nxt = '0;
                    state_nxt    = SCAN;
                end else if (cnt == DEB_LAST) begin
                    cnt_nxt   = DEB_FULL;
                    valid_nxt = 1'b1;
                    code_nxt  = decode(row_idx, pat);
                    pulse_nxt = 1'b1;
                    state_nxt = PRESSED;
                end else if (cnt < DEB_FULL) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            PRESSED: begin
                // Extra or different keys while held are ignored; only idle counts.
                if (col_s == IDLE) begin
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (col_s != IDLE) begin
                    cnt_nxt   = '0;
                    state_nxt = PRESSED;
                end else if (cnt == DEB_LAST) begin
                    cnt_nxt      = '0;
                    valid_nxt    = 1'b0;
                    row_nxt      = row_idx + 2'd1;
                    scan_cnt_nxt = '0;
                    state_nxt    = SCAN;
                end else if (cnt < DEB_FULL) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

endmodule
